// File: rtl/onehot_pos_display.sv
// Checks and encodes a rotating one-hot position vector and shows the index in decimal
// on a time-multiplexed 8-digit active-low 7-segment display.
module onehot_pos_display #(
  parameter  int WIDTH    = 21,
  parameter  int SCAN_DIV = 100000,
  localparam int IW       = $clog2(WIDTH),
  localparam int CW       = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] onehot_in,
  input  logic             clr_err,
  output logic [IW-1:0]    pos_out,
  output logic             pos_valid,
  output logic             pos_changed,
  output logic             err_sticky,
  output logic [7:0]       an,
  output logic [7:0]       seg
);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Compare-subtract binary to {tens, units}; inputs never exceed 98.
  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [6:0] r;
    logic [3:0] t;
    r = bin;
    t = 4'd0;
    if (r >= 7'd80) begin r = r - 7'd80; t = t + 4'd8; end
    if (r >= 7'd40) begin r = r - 7'd40; t = t + 4'd4; end
    if (r >= 7'd20) begin r = r - 7'd20; t = t + 4'd2; end
    if (r >= 7'd10) begin r = r - 7'd10; t = t + 4'd1; end
    return {t, r[3:0]};
  endfunction

  logic [WIDTH-1:0] oh_q, oh_d;
  logic             s1_vld_q, s1_vld_d;
  logic [IW-1:0]    pos_q, pos_d;
  logic             pos_valid_q, pos_valid_d;
  logic             pos_changed_q, pos_changed_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic             oh_ok;
  logic [IW-1:0]    idx;
  logic [7:0]       bcd;
  logic             cnt_wrap;

  // Stage 1: sample the input; s1_vld marks that the sample is real, not the reset value.
  always_comb begin
    oh_d     = onehot_in;
    s1_vld_d = 1'b1;
  end

  // Stage 2: legality check, encode, change detect and sticky error.
  always_comb begin
    oh_ok = (oh_q != '0) && ((oh_q & (oh_q - WIDTH'(1))) == '0);
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh_q[i]) idx = idx | IW'(i);
    end

    pos_d         = pos_q;
    pos_valid_d   = 1'b0;
    pos_changed_d = 1'b0;
    err_d         = err_q;
    if (s1_vld_q) begin
      pos_valid_d = oh_ok;
      if (oh_ok) begin
        pos_d         = idx;
        pos_changed_d = (idx != pos_q);
      end
    end
    if (clr_err) err_d = 1'b0;
    if (s1_vld_q && !oh_ok) err_d = 1'b1;
  end

  // Display scan: digit slot timer, digit select and registered an/seg.
  always_comb begin
    bcd      = to_bcd(7'(pos_q));
    cnt_wrap = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
    sel_d    = cnt_wrap ? sel_q + 3'd1 : sel_q;
    an_d     = ~(8'b1 << sel_q);
    seg_d    = SEG_BLANK;
    if (pos_valid_q) begin
      if (sel_q == 3'd0) seg_d = seg7(bcd[3:0]);
      else if (sel_q == 3'd1 && bcd[7:4] != 4'd0) seg_d = seg7(bcd[7:4]);
    end else begin
      if (sel_q == 3'd0) seg_d = SEG_DASH;
      else if (sel_q == 3'd1) seg_d = SEG_E;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oh_q          <= '0;
      s1_vld_q      <= 1'b0;
      pos_q         <= '0;
      pos_valid_q   <= 1'b0;
      pos_changed_q <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      sel_q         <= 3'd0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
    end else begin
      oh_q          <= oh_d;
      s1_vld_q      <= s1_vld_d;
      pos_q         <= pos_d;
      pos_valid_q   <= pos_valid_d;
      pos_changed_q <= pos_changed_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign pos_out     = pos_q;
  assign pos_valid   = pos_valid_q;
  assign pos_changed = pos_changed_q;
  assign err_sticky  = err_q;
  assign an          = an_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_onehot_pos_display.sv
// Scoreboard bench for onehot_pos_display: encode pipeline, sticky error and display scan.
module tb_onehot_pos_display;

  localparam int W  = 21;
  localparam int SD = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] pos;
    logic       chg;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] onehot_in;
  logic         clr_err;
  logic [4:0]   pos_out;
  logic         pos_valid;
  logic         pos_changed;
  logic         err_sticky;
  logic [7:0]   an;
  logic [7:0]   seg;

  int         n_tests;
  int         n_fail;
  int         ecount;
  int         chg_seen;
  logic [4:0] m_pos;
  logic       m_err;
  exp_t       sb[$];

  onehot_pos_display #(.WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .onehot_in   (onehot_in),
    .clr_err     (clr_err),
    .pos_out     (pos_out),
    .pos_valid   (pos_valid),
    .pos_changed (pos_changed),
    .err_sticky  (err_sticky),
    .an          (an),
    .seg         (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, push the expectation, then compare the entry whose output is due.
  task automatic tick(input logic [W-1:0] v, input logic clr);
    exp_t e;
    logic ok;
    int   idx;
    onehot_in = v;
    clr_err   = clr;
    ok  = $onehot(v);
    idx = 0;
    for (int i = 0; i < W; i++) if (v[i]) idx = i;
    e.valid = ok;
    e.pos   = ok ? 5'(idx) : m_pos;
    e.chg   = ok && (5'(idx) != m_pos);
    if (ok) m_pos = 5'(idx);
    sb.push_back(e);
    @(posedge clk);
    #1;
    ecount++;
    if (pos_changed === 1'b1) chg_seen++;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      m_err = !e.valid ? 1'b1 : (clr ? 1'b0 : m_err);
      n_tests++;
      if (pos_out !== e.pos) begin
        n_fail++;
        $display("FAIL sb_pos_out t=%0t got %0d expected %0d", $time, pos_out, e.pos);
      end
      n_tests++;
      if (pos_valid !== e.valid) begin
        n_fail++;
        $display("FAIL sb_pos_valid t=%0t got %0b expected %0b", $time, pos_valid, e.valid);
      end
      n_tests++;
      if (pos_changed !== e.chg) begin
        n_fail++;
        $display("FAIL sb_pos_changed t=%0t got %0b expected %0b", $time, pos_changed, e.chg);
      end
      n_tests++;
      if (err_sticky !== m_err) begin
        n_fail++;
        $display("FAIL sb_err_sticky t=%0t got %0b expected %0b", $time, err_sticky, m_err);
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pos  = 5'd0;
    m_err  = 1'b0;
    ecount = 0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    onehot_in = 21'h1;
    clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({pos_out, pos_valid, pos_changed, err_sticky} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_flags got pos=%0d v=%0b c=%0b e=%0b expected all 0",
               pos_out, pos_valid, pos_changed, err_sticky);
    end
    n_tests++;
    if ({an, seg} !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_display got an=%h seg=%h expected FF FF", an, seg);
    end
    rst_n = 1'b1;
    model_reset();
    tick(21'h1, 1'b0);
    n_tests++;
    if (an !== 8'hFE) begin
      n_fail++;
      $display("FAIL first_digit got an=%h expected FE", an);
    end
    tick(21'h1, 1'b0);
    n_tests++;
    if ({pos_out, pos_valid, pos_changed, err_sticky} !== {5'd0, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_first_valid got pos=%0d v=%0b c=%0b e=%0b expected 0 1 0 0",
               pos_out, pos_valid, pos_changed, err_sticky);
    end
  endtask

  task automatic test_rotate();
    int base;
    base = chg_seen;
    for (int s = 1; s <= W; s++) begin
      repeat (3) tick(21'b1 << (s % W), 1'b0);
    end
    n_tests++;
    if (chg_seen - base != W) begin
      n_fail++;
      $display("FAIL rotate_pulses got %0d expected %0d", chg_seen - base, W);
    end
    n_tests++;
    if (pos_out !== 5'd0) begin
      n_fail++;
      $display("FAIL rotate_wrap got %0d expected 0", pos_out);
    end
  endtask

  task automatic test_invalid();
    repeat (3) tick(21'b1 << 9, 1'b0);
    repeat (3) tick(21'h0, 1'b0);
    n_tests++;
    if ({pos_out, pos_valid, err_sticky} !== {5'd9, 2'b01}) begin
      n_fail++;
      $display("FAIL invalid_zero got pos=%0d v=%0b e=%0b expected 9 0 1",
               pos_out, pos_valid, err_sticky);
    end
    repeat (3) tick(21'h3, 1'b0);
    n_tests++;
    if ({pos_out, pos_valid} !== {5'd9, 1'b0}) begin
      n_fail++;
      $display("FAIL invalid_two got pos=%0d v=%0b expected 9 0", pos_out, pos_valid);
    end
    repeat (3) tick(21'h10, 1'b0);
    n_tests++;
    if ({pos_out, pos_valid, err_sticky} !== {5'd4, 2'b11}) begin
      n_fail++;
      $display("FAIL invalid_restore got pos=%0d v=%0b e=%0b expected 4 1 1",
               pos_out, pos_valid, err_sticky);
    end
  endtask

  task automatic test_clr_err();
    tick(21'h0, 1'b0);
    tick(21'h0, 1'b1);
    n_tests++;
    if (err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_set got %0b expected 1", err_sticky);
    end
    tick(21'b1 << 7, 1'b0);
    tick(21'b1 << 7, 1'b0);
    tick(21'b1 << 7, 1'b1);
    n_tests++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_alone got %0b expected 0", err_sticky);
    end
    tick(21'b1 << 7, 1'b0);
  endtask

  // Holds one input and checks 4*8 scan slots; u/t are the expected codes for digits 0 and 1.
  task automatic scan_check(input logic [W-1:0] v, input logic [7:0] u, input logic [7:0] t);
    int         sel;
    logic [7:0] ea;
    logic [7:0] es;
    repeat (4) tick(v, 1'b0);
    for (int k = 0; k < 8 * SD; k++) begin
      tick(v, 1'b0);
      sel = ((ecount - 1) / SD) % 8;
      ea  = ~(8'b1 << sel);
      es  = (sel == 0) ? u : (sel == 1) ? t : 8'hFF;
      n_tests++;
      if (an !== ea) begin
        n_fail++;
        $display("FAIL scan_an t=%0t got %h expected %h", $time, an, ea);
      end
      n_tests++;
      if (seg !== es) begin
        n_fail++;
        $display("FAIL scan_seg t=%0t an=%h got %h expected %h", $time, an, seg, es);
      end
    end
  endtask

  task automatic test_display();
    scan_check(21'b1 << 17, 8'hF8, 8'hF9);
    scan_check(21'b1 << 5,  8'h92, 8'hFF);
    scan_check(21'b1 << 20, 8'hC0, 8'hA4);
    scan_check(21'h0,       8'hBF, 8'h86);
  endtask

  task automatic test_midscan_reset();
    repeat (6) tick(21'b1 << 12, 1'b0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({an, seg} !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL midscan_display got an=%h seg=%h expected FF FF", an, seg);
    end
    n_tests++;
    if ({pos_out, pos_valid, err_sticky} !== 7'h0) begin
      n_fail++;
      $display("FAIL midscan_flags got pos=%0d v=%0b e=%0b expected 0 0 0",
               pos_out, pos_valid, err_sticky);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2 * SD; k++) begin
      tick(21'b1 << 3, 1'b0);
      n_tests++;
      if (an !== ((k < SD) ? 8'hFE : 8'hFD)) begin
        n_fail++;
        $display("FAIL midscan_restart k=%0d got an=%h expected %h",
                 k, an, (k < SD) ? 8'hFE : 8'hFD);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    chg_seen = 0;
    model_reset();
    test_reset();
    test_rotate();
    test_invalid();
    test_clr_err();
    test_display();
    test_midscan_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
